// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared grant encoding and default widths for the frame buffer arbiter
package fb_pkg;

  localparam int FB_ADDR_W      = 16;
  localparam int FB_DATA_W      = 16;
  localparam int FB_WFIFO_DEPTH = 4;
  localparam int FB_LEVEL_W     = 5;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_e;

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// rtl/frame_buffer_arbiter_if.sv - display read, writer and RAM signals of the frame buffer arbiter
interface frame_buffer_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);

  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [FB_LEVEL_W-1:0] wfifo_level;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output rd_data, rd_valid, wr_ready, wfifo_level, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  rd_data, rd_valid, wr_ready, wfifo_level, ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - write buffer: power-of-two depth FIFO with registered level
module sync_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [WIDTH-1:0]   i_data,
  output logic [WIDTH-1:0]   o_data,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic               w_push_ok;
  logic               w_pop_ok;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign w_push_ok = i_push && (r_level != LEVEL_W'(DEPTH));
  assign w_pop_ok  = i_pop && (r_level != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LEVEL_W'(1);
        2'b01:   r_level <= r_level - LEVEL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - single-port frame RAM arbiter: display reads win, writes buffered
module frame_buffer_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int WFIFO_DEPTH = FB_WFIFO_DEPTH
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  frame_buffer_arbiter_if.slave  bus
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0]    w_head;
  logic [FB_LEVEL_W-1:0] w_level;
  logic                  w_empty;
  logic                  w_wr_ready;
  logic                  w_push;
  logic                  w_pop;
  grant_e                w_grant;

  logic                  r_rst_done;
  logic [ADDR_W-1:0]     r_ram_addr;
  logic [DATA_W-1:0]     r_ram_wdata;
  logic                  r_ram_we;
  logic                  r_rd_p1;
  logic                  r_rd_p2;
  logic                  r_rd_valid;
  logic [DATA_W-1:0]     r_rd_data;

  assign w_wr_ready = r_rst_done && (w_level < FB_LEVEL_W'(WFIFO_DEPTH));
  assign w_push     = bus.wr_valid && w_wr_ready;

  always_comb begin
    w_grant = GNT_IDLE;
    if (bus.rd_req)    w_grant = GNT_READ;
    else if (!w_empty) w_grant = GNT_WRITE;
  end

  assign w_pop = (w_grant == GNT_WRITE);

  sync_fifo #(
    .WIDTH   (ENTRY_W),
    .DEPTH   (WFIFO_DEPTH),
    .LEVEL_W (FB_LEVEL_W)
  ) u_wfifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.wr_addr, bus.wr_data}),
    .o_data  (w_head),
    .o_level (w_level),
    .o_empty (w_empty)
  );

  // Read pipeline: address out (k+1), RAM data (k+2), captured and flagged valid (k+3).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_done  <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_rd_p1     <= 1'b0;
      r_rd_p2     <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_rst_done <= 1'b1;
      r_ram_we   <= (w_grant == GNT_WRITE);
      case (w_grant)
        GNT_READ:  r_ram_addr <= bus.rd_addr;
        GNT_WRITE: begin
          r_ram_addr  <= w_head[ENTRY_W-1:DATA_W];
          r_ram_wdata <= w_head[DATA_W-1:0];
        end
        default:   r_ram_addr <= r_ram_addr;
      endcase
      r_rd_p1    <= (w_grant == GNT_READ);
      r_rd_p2    <= r_rd_p1;
      r_rd_valid <= r_rd_p2;
      if (r_rd_p2) r_rd_data <= bus.ram_rdata;
    end
  end

  assign bus.wr_ready    = w_wr_ready;
  assign bus.wfifo_level = w_level;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_wdata   = r_ram_wdata;
  assign bus.ram_we      = r_ram_we;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_data     = r_rd_data;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - randomized and directed bench for frame_buffer_arbiter against a queue model
`timescale 1ns/1ps
module tb_frame_buffer_arbiter;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #12.5 clk = ~clk;

  frame_buffer_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  frame_buffer_arbiter #(.ADDR_W(16), .DATA_W(16), .WFIFO_DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // Registered-address RAM; unwritten words read back a fixed address pattern.
  logic [15:0] ram [int];
  logic        pre_we = 1'b0;
  logic [15:0] pre_a = '0;
  logic [15:0] pre_d = '0;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  always @(posedge clk) begin
    logic [15:0] rd_tmp;
    rd_tmp = ram.exists(int'(bus.ram_addr)) ? ram[int'(bus.ram_addr)] : pat(bus.ram_addr);
    if (bus.ram_we) ram[int'(bus.ram_addr)] = bus.ram_wdata;
    if (pre_we)     ram[int'(pre_a)] = pre_d;
    bus.ram_rdata <= rd_tmp;
  end

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         q[$];
  logic [15:0] gold [int];
  bit          sh_v [3];
  logic [15:0] sh_d [3];
  bit          exp_we;
  logic [15:0] exp_wa, exp_wd;
  bit          m_rst_done;
  int          n_cmp = 0, n_err = 0, n_we = 0, n_valid = 0;

  function automatic logic [15:0] gold_rd(input logic [15:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : pat(a);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rd, input logic [15:0] ra, input bit wv,
                      input logic [15:0] wa, input logic [15:0] wd);
    bit          rdy, nv;
    logic [15:0] nd;
    wr_t         e;
    bus.rd_req = rd; bus.rd_addr = ra;
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
    rdy = m_rst_done && (q.size() < 4);
    @(posedge clk);
    if (exp_we) gold[int'(exp_wa)] = exp_wd;
    exp_we = 1'b0;
    nv = 1'b0;
    nd = '0;
    if (rd) begin
      nv = 1'b1;
      nd = gold_rd(ra);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_we = 1'b1; exp_wa = e.a; exp_wd = e.d;
    end
    if (wv && rdy) begin
      e.a = wa; e.d = wd;
      q.push_back(e);
    end
    sh_v[2] = sh_v[1]; sh_d[2] = sh_d[1];
    sh_v[1] = sh_v[0]; sh_d[1] = sh_d[0];
    sh_v[0] = nv;      sh_d[0] = nd;
    m_rst_done = 1'b1;
    #1;
    check_eq("wr_ready", bus.wr_ready, (q.size() < 4));
    check_eq("wfifo_level", bus.wfifo_level, q.size());
    check_eq("ram_we", bus.ram_we, exp_we);
    if (exp_we) begin
      check_eq("ram_addr", bus.ram_addr, exp_wa);
      check_eq("ram_wdata", bus.ram_wdata, exp_wd);
    end
    check_eq("rd_valid", bus.rd_valid, sh_v[2]);
    if (sh_v[2]) check_eq("rd_data", bus.rd_data, sh_d[2]);
    if (bus.ram_we) n_we++;
    if (bus.rd_valid) n_valid++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_valid"}, bus.rd_valid, 0);
    check_eq({tag, "_ram_we"}, bus.ram_we, 0);
    check_eq({tag, "_ram_addr"}, bus.ram_addr, 0);
    check_eq({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    check_eq({tag, "_rd_data"}, bus.rd_data, 0);
    check_eq({tag, "_wr_ready"}, bus.wr_ready, 0);
    check_eq({tag, "_level"}, bus.wfifo_level, 0);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
    gold[int'(a)] = d;
  endtask

  task automatic do_reset(input int n);
    bus.rd_req = 1'b0; bus.wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    q.delete();
    for (int i = 0; i < 3; i++) begin
      sh_v[i] = 1'b0;
      sh_d[i] = '0;
    end
    exp_we = 1'b0;
    m_rst_done = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    #1;
    check_eq("wr_ready_at_release", bus.wr_ready, 0);
  endtask

  initial begin
    int we0, v0, pct;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    rst_n = 1'b0;
    #3;
    preload(16'h0010, 16'hF800);
    preload(16'h0020, 16'h001F);
    do_reset(2);

    // Single read: three-cycle latency.
    step(1'b1, 16'h0010, 1'b0, '0, '0);
    idle(2);
    check_eq("single_valid", bus.rd_valid, 1);
    check_eq("single_data", bus.rd_data, 16'hF800);
    idle(1);

    // 800-word display burst.
    we0 = n_we; v0 = n_valid;
    for (int i = 0; i < 800; i++) step(1'b1, 16'(i), 1'b0, '0, '0);
    idle(3);
    check_eq("burst_valid_cnt", n_valid - v0, 800);
    check_eq("burst_we_cnt", n_we - we0, 0);

    // Writes during blanking.
    we0 = n_we;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 16'h0100 + 16'(i), 16'h07E0);
    idle(4);
    check_eq("blank_we_cnt", n_we - we0, 4);
    check_eq("blank_level", bus.wfifo_level, 0);

    // Reads starve writes until the FIFO fills, then drain.
    we0 = n_we;
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b1, 16'h0200 + 16'(i), 16'h1000 + 16'(i));
    check_eq("starve_level", bus.wfifo_level, 4);
    check_eq("starve_ready", bus.wr_ready, 0);
    check_eq("starve_we_cnt", n_we - we0, 0);
    idle(6);
    check_eq("drain_we_cnt", n_we - we0, 4);
    check_eq("drain_ready", bus.wr_ready, 1);

    // Same-cycle read and write to one address.
    step(1'b1, 16'h0020, 1'b1, 16'h0020, 16'hFFFF);
    idle(2);
    check_eq("collide_old", bus.rd_data, 16'h001F);
    idle(2);
    step(1'b1, 16'h0020, 1'b0, '0, '0);
    idle(2);
    check_eq("collide_new", bus.rd_data, 16'hFFFF);
    idle(1);

    // Reset with buffered writes and reads in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0300 + 16'(i), 1'b1, 16'h0400 + 16'(i), 16'hABC0 + 16'(i));
    check_eq("pre_rst_level", bus.wfifo_level, 3);
    do_reset(2);
    we0 = n_we; v0 = n_valid;
    idle(1);
    check_eq("ready_after_rst", bus.wr_ready, 1);
    idle(5);
    check_eq("post_rst_we_cnt", n_we - we0, 0);
    check_eq("post_rst_valid_cnt", n_valid - v0, 0);

    // Randomized traffic with a varying read duty.
    for (int blk = 0; blk < 30; blk++) begin
      pct = $urandom_range(0, 100);
      if (blk == 15) do_reset(1);
      for (int i = 0; i < 100; i++)
        step(($urandom_range(0, 99) < pct), 16'($urandom_range(0, 31)),
             $urandom_range(0, 1) == 1, 16'($urandom_range(0, 31)), 16'($urandom));
    end
    idle(10);
    check_eq("final_level", bus.wfifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
